uart_tx_frame_ctrl: RTL and testbench

//  Parametrised UART transmitter for the multi-clock system's TX path. It serialises one

---
 rtl/uart_tx_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1..2 stop bits; registered line output.
// Optional macro UART_TX_HOLD_REG_EN adds a one-entry holding register for back-to-back frames.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  DATA_ACK,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  tx_q, tx_d;
  logic                  ack_q, ack_d;
  logic                  bit_end, frame_end, load_in, bit_sel;

`ifdef UART_TX_HOLD_REG_EN
  logic                  hvld_q, hvld_d;
  logic [DATA_WIDTH-1:0] hdata_q, hdata_d;
  logic                  hpen_q, hpen_d;
  logic                  hptyp_q, hptyp_d;
  logic                  load_hold, hold_store;
`endif

  assign bit_end   = (tmr_q == TW'(CLKS_PER_BIT - 1));
  assign frame_end = (state_q == ST_STOP) && bit_end && (idx_q == IW'(STOP_BITS - 1));

  always_comb begin
    state_d = state_q;
    tmr_d   = bit_end ? '0 : tmr_q + TW'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    load_in = 1'b0;
`ifdef UART_TX_HOLD_REG_EN
    hvld_d     = hvld_q;
    hdata_d    = hdata_q;
    hpen_d     = hpen_q;
    hptyp_d    = hptyp_q;
    load_hold  = 1'b0;
    hold_store = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        tmr_d   = '0;
        load_in = DATA_VALID;
      end
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        idx_d   = '0;
      end
      ST_DATA: if (bit_end) begin
        if (idx_q == IW'(DATA_WIDTH - 1)) begin
          idx_d   = '0;
          state_d = pen_q ? ST_PARITY : ST_STOP;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d = ST_STOP;
        idx_d   = '0;
      end
      ST_STOP: begin
        if (frame_end)    state_d = ST_IDLE;
        else if (bit_end) idx_d   = idx_q + IW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef UART_TX_HOLD_REG_EN
    // A held word wins at frame end; otherwise a fresh request goes straight to the shift path.
    if (frame_end) begin
      if (hvld_q) begin
        load_hold = 1'b1;
        hvld_d    = 1'b0;
      end else begin
        load_in = DATA_VALID;
      end
    end else if ((state_q != ST_IDLE) && !hvld_q && DATA_VALID) begin
      hold_store = 1'b1;
      hvld_d     = 1'b1;
      hdata_d    = P_DATA;
      hpen_d     = PAR_EN;
      hptyp_d    = PAR_TYP;
    end
    if (load_hold) begin
      state_d = ST_START;
      tmr_d   = '0;
      idx_d   = '0;
      data_d  = hdata_q;
      pen_d   = hpen_q;
      ptyp_d  = hptyp_q;
    end
`endif

    if (load_in) begin
      state_d = ST_START;
      tmr_d   = '0;
      idx_d   = '0;
      data_d  = P_DATA;
      pen_d   = PAR_EN;
      ptyp_d  = PAR_TYP;
    end

`ifdef UART_TX_HOLD_REG_EN
    ack_d = load_in | hold_store;
`else
    ack_d = load_in;
`endif

    bit_sel = 1'b0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (idx_d == IW'(k)) bit_sel = data_d[k];
    end

    // Line value is derived from the next state so TX_OUT is registered yet aligned with state_q.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = bit_sel;
      ST_PARITY: tx_d = (^data_d) ^ ptyp_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
`ifdef UART_TX_HOLD_REG_EN
      hvld_q  <= 1'b0;
      hdata_q <= '0;
      hpen_q  <= 1'b0;
      hptyp_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
`ifdef UART_TX_HOLD_REG_EN
      hvld_q  <= hvld_d;
      hdata_q <= hdata_d;
      hpen_q  <= hpen_d;
      hptyp_q <= hptyp_d;
`endif
    end
  end

  assign TX_OUT   = tx_q;
  assign DATA_ACK = ack_q;
`ifdef UART_TX_HOLD_REG_EN
  assign Busy = (state_q != ST_IDLE) | hvld_q;
`else
  assign Busy = (state_q != ST_IDLE);
`endif

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: frame-level reference model checked every cycle on two instances
// (1 and 2 stop bits), directed literal checks, then randomized traffic with sporadic resets.
module tb_uart_tx_frame_ctrl;
  localparam int W   = 8;
  localparam int CPB = 4;

  logic         CLK, RST, DATA_VALID, PAR_EN, PAR_TYP;
  logic [W-1:0] P_DATA;
  logic         ack0, tx0, busy0, ack1, tx1, busy1;

  int tests = 0;
  int fails = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .DATA_ACK(ack0), .TX_OUT(tx0), .Busy(busy0));
  uart_tx_frame_ctrl #(.DATA_WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .DATA_ACK(ack1), .TX_OUT(tx1), .Busy(busy1));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a bit vector; the line shows bit (cycles elapsed / CPB).
  int          flen[2];
  int          pos[2];
  logic [15:0] fb[2];
  logic        hv[2];
  logic [7:0]  hd[2];
  logic        hpe[2], hpt[2];
  logic        eack[2];
  int          stops[2];
  bit          mdl_rdy = 0;

  initial begin
    stops[0] = 1; stops[1] = 2;
    for (int i = 0; i < 2; i++) begin
      flen[i] = 0; pos[i] = 0; hv[i] = 0; eack[i] = 0; fb[i] = '1;
      hd[i] = '0; hpe[i] = 0; hpt[i] = 0;
    end
  end

  task automatic start_frame(input int i, input logic [7:0] d, input logic pe, input logic pt);
    logic [15:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int k = 0; k < W; k++) b[1+k] = d[k];
    if (pe) b[1+W] = (^d) ^ pt;
    fb[i]   = b;
    flen[i] = (1 + W + int'(pe) + stops[i]) * CPB;
    pos[i]  = 0;
  endtask

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      int rem;
      rem     = flen[i] - pos[i];
      eack[i] = 1'b0;
      if (!RST) begin
        flen[i] = 0; pos[i] = 0; hv[i] = 1'b0;
      end else begin
        if (rem > 0) pos[i]++;
`ifdef UART_TX_HOLD_REG_EN
        if (rem == 1 && hv[i]) begin
          start_frame(i, hd[i], hpe[i], hpt[i]);
          hv[i] = 1'b0;
        end else if (rem <= 1 && DATA_VALID) begin
          start_frame(i, P_DATA, PAR_EN, PAR_TYP);
          eack[i] = 1'b1;
        end else if (rem > 1 && !hv[i] && DATA_VALID) begin
          hv[i] = 1'b1; hd[i] = P_DATA; hpe[i] = PAR_EN; hpt[i] = PAR_TYP;
          eack[i] = 1'b1;
        end
`else
        if (rem <= 0 && DATA_VALID) begin
          start_frame(i, P_DATA, PAR_EN, PAR_TYP);
          eack[i] = 1'b1;
        end
`endif
      end
    end
    mdl_rdy = 1;
  end

  function automatic logic exp_tx(input int i);
    if (pos[i] < flen[i]) return fb[i][pos[i] / CPB];
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int i);
    return (pos[i] < flen[i]) || hv[i];
  endfunction

  always @(negedge CLK) begin
    if (mdl_rdy) begin
      check("tx_s1",   {31'd0, tx0},   {31'd0, exp_tx(0)});
      check("busy_s1", {31'd0, busy0}, {31'd0, exp_busy(0)});
      check("ack_s1",  {31'd0, ack0},  {31'd0, eack[0]});
      check("tx_s2",   {31'd0, tx1},   {31'd0, exp_tx(1)});
      check("busy_s2", {31'd0, busy1}, {31'd0, exp_busy(1)});
      check("ack_s2",  {31'd0, ack1},  {31'd0, eack[1]});
    end
  end

  // Directed helpers
  logic s_tx1[200], s_b1[200], s_a1[200], s_tx2[200], s_b2[200];

  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    @(posedge CLK); #2;
    DATA_VALID = 1'b1; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
    @(posedge CLK); #2;
    DATA_VALID = 1'b0;
  endtask

  task automatic sample(input int n, input int p1, input logic [7:0] d1,
                        input int p2, input logic [7:0] d2);
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      s_tx1[c] = tx0; s_b1[c] = busy0; s_a1[c] = ack0;
      s_tx2[c] = tx1; s_b2[c] = busy1;
      if (c == p1) begin DATA_VALID = 1'b1; P_DATA = d1; end
      else if (c == p2) begin DATA_VALID = 1'b1; P_DATA = d2; end
      else DATA_VALID = 1'b0;
    end
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy0 || busy1) && w < 300) begin
      @(negedge CLK);
      w++;
    end
    check("wait_idle", {30'd0, busy0, busy1}, 32'd0);
  endtask

  function automatic logic [9:0] frame10(input int base);
    logic [9:0] v;
    for (int k = 0; k < 10; k++) v[k] = s_tx1[base + k*CPB + 2];
    return v;
  endfunction

  function automatic int count1(input int a, input int b, input bit which);
    int n;
    n = 0;
    for (int c = a; c <= b; c++) n += which ? int'(s_b2[c]) : int'(s_b1[c]);
    return n;
  endfunction

  initial begin
    int busy_n, ack_n, gap, stop_hi;
    bit fell, done;
    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    check("reset_tx",   {31'd0, tx0},   32'd1);
    check("reset_busy", {31'd0, busy0}, 32'd0);
    check("reset_ack",  {31'd0, ack0},  32'd0);

    // 8'hA5, no parity
    send(8'hA5, 1'b0, 1'b0);
    sample(50, -1, 8'h00, -1, 8'h00);
    check("a5_ack_first", {31'd0, s_a1[0]}, 32'd1);
    check("a5_bits", {22'd0, frame10(0)}, {22'd0, 10'b11_0100_1010});
    check("a5_busy_len", count1(0, 49, 0), 40);
    wait_idle();

    // parity even / odd on 8'h07
    send(8'h07, 1'b1, 1'b0);
    sample(50, -1, 8'h00, -1, 8'h00);
    check("par_even_bit", {31'd0, s_tx1[9*CPB+2]}, 32'd1);
    check("par_busy_len", count1(0, 49, 0), 44);
    wait_idle();
    send(8'h07, 1'b1, 1'b1);
    sample(50, -1, 8'h00, -1, 8'h00);
    check("par_odd_bit", {31'd0, s_tx1[9*CPB+2]}, 32'd0);
    wait_idle();

    // two stop bits
    send(8'hFF, 1'b0, 1'b0);
    sample(50, -1, 8'h00, -1, 8'h00);
    stop_hi = 0;
    for (int c = 36; c < 44; c++) stop_hi += int'(s_tx2[c]);
    check("stop2_high", stop_hi, 8);
    check("stop2_busy_len", count1(0, 49, 1), 44);
    wait_idle();

`ifndef UART_TX_HOLD_REG_EN
    // DATA_VALID held high: one idle cycle between frames
    @(posedge CLK); #2;
    DATA_VALID = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b0;
    fell = 0; done = 0; gap = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (!busy1 && c > 2) begin fell = 1; gap++; end
      else if (busy1 && fell) begin
        check("held_gap", gap, 1);
        check("held_start", {31'd0, tx1}, 32'd0);
        done = 1;
      end
    end
    check("held_done", {31'd0, done}, 32'd1);
    DATA_VALID = 1'b0;
    wait_idle();

    // request while busy is dropped
    send(8'h5A, 1'b0, 1'b0);
    sample(50, 10, 8'h00, -1, 8'h00);
    ack_n = 0;
    for (int c = 0; c < 50; c++) ack_n += int'(s_a1[c]);
    check("busy_req_acks", ack_n, 1);
    check("busy_req_bits", {22'd0, frame10(0)}, {22'd0, 10'b10_1011_0100});
    check("busy_req_len", count1(0, 49, 0), 40);
    wait_idle();
`else
    // back-to-back through the holding register, third word refused
    send(8'h11, 1'b0, 1'b0);
    sample(95, 10, 8'h22, 20, 8'h33);
    ack_n = 0;
    for (int c = 0; c < 95; c++) ack_n += int'(s_a1[c]);
    check("hold_acks", ack_n, 2);
    check("hold_busy_len", count1(0, 94, 0), 80);
    check("hold_no_gap", {30'd0, s_tx1[39], s_tx1[40]}, 32'd2);
    check("hold_bits2", {22'd0, frame10(40)}, {22'd0, 10'b10_0100_0100});
    wait_idle();
`endif

    // reset during d3, then resend 8'h3C
    send(8'h3C, 1'b0, 1'b0);
    for (int c = 0; c < 18; c++) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_tx",   {31'd0, tx0},   32'd1);
    check("rst_mid_busy", {31'd0, busy0}, 32'd0);
    RST = 1'b1;
    send(8'h3C, 1'b0, 1'b0);
    sample(45, -1, 8'h00, -1, 8'h00);
    check("after_rst_bits", {22'd0, frame10(0)}, {22'd0, 10'b10_0111_1000});
    wait_idle();

    // randomized traffic with occasional reset
    for (int c = 0; c < 4000; c++) begin
      @(posedge CLK); #2;
      DATA_VALID = ($urandom_range(0, 5) == 0);
      P_DATA     = W'($urandom);
      PAR_EN     = $urandom_range(0, 1) == 1;
      PAR_TYP    = $urandom_range(0, 1) == 1;
      RST        = ($urandom_range(0, 399) != 0);
    end
    @(posedge CLK); #2;
    DATA_VALID = 1'b0; RST = 1'b1;
    wait_idle();
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
